// File: rtl/sm4_ctrl_if.sv
// sm4_ctrl_if: host-side block handshake (input valid/ready, output valid/ready) for sm4_ctrl.
interface sm4_ctrl_if;
   logic         i_flag;
   logic [127:0] i_din;
   logic         i_din_valid;
   logic         o_din_ready;
   logic [127:0] o_dout;
   logic         o_dout_valid;
   logic         i_dout_ready;
   modport master (output i_flag, i_din, i_din_valid, i_dout_ready,
                   input  o_din_ready, o_dout, o_dout_valid);
   modport slave  (input  i_flag, i_din, i_din_valid, i_dout_ready,
                   output o_din_ready, o_dout, o_dout_valid);
endinterface

// File: rtl/sm4_ctrl.sv
// sm4_ctrl: sequences one SM4 block through an external round core (IDLE->LOAD->RUN->OUT).
// Optional RUN watchdog with sticky o_err is enabled by defining SM4_CTRL_TIMEOUT_EN.
module sm4_ctrl (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_key_ok,
   sm4_ctrl_if.slave    bus,
   output logic         o_core_flag,
   output logic [127:0] o_core_din,
   output logic         o_core_din_en,
   input  logic [127:0] i_core_dout,
   input  logic         i_core_dout_en,
   output logic         o_busy,
   output logic         o_err
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} state_t;
   state_t       state_q, state_d;
   logic [5:0]   cnt_q, cnt_d;
   logic [127:0] din_q, din_d, dout_q, dout_d;
   logic         flag_q, flag_d;
   logic         accept, timeout;

   assign accept = bus.i_din_valid & bus.o_din_ready;

`ifdef SM4_CTRL_TIMEOUT_EN
   logic err_q;
   assign timeout = (state_q == RUN) & ~i_core_dout_en & (cnt_q == 6'd40);
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) err_q <= 1'b0;
      else if (timeout) err_q <= 1'b1;
   assign o_err = err_q;
`else
   assign timeout = 1'b0;
   assign o_err   = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         din_q   <= '0;
         flag_q  <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         din_q   <= din_d;
         flag_q  <= flag_d;
         dout_q  <= dout_d;
      end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = accept ? LOAD : IDLE;
         LOAD:    state_d = RUN;
         RUN:     state_d = i_core_dout_en ? OUT : timeout ? IDLE : RUN;
         OUT:     state_d = bus.i_dout_ready ? IDLE : OUT;
         default: state_d = IDLE;
      endcase
   end

   // Core results are only taken in RUN; strobes in any other state are ignored.
   always_comb begin
      cnt_d  = (state_q == LOAD) ? 6'd0 : (state_q == RUN && cnt_q != 6'd63) ? cnt_q + 6'd1 : cnt_q;
      din_d  = accept ? bus.i_din : din_q;
      flag_d = accept ? bus.i_flag : flag_q;
      dout_d = (state_q == RUN && i_core_dout_en) ? i_core_dout : dout_q;
   end

   always_comb begin
      bus.o_din_ready  = (state_q == IDLE) & i_key_ok;
      bus.o_dout_valid = state_q == OUT;
      bus.o_dout       = dout_q;
      o_core_din_en    = state_q == LOAD;
      o_core_din       = din_q;
      o_core_flag      = flag_q;
      o_busy           = state_q != IDLE;
   end
endmodule

// File: tb/tb_sm4_ctrl.sv
// tb_sm4_ctrl: directed bench for sm4_ctrl with a fixed-latency stub core answering the SM4 known-answer pair.
module tb_sm4_ctrl;
   localparam logic [127:0] PT  = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] CT  = 128'h681edf34d206965e86b3e94f536e4246;
   localparam logic [127:0] OVR = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

   logic         clk = 1'b0, rst_n = 1'b0, key_ok = 1'b1;
   logic         core_flag, core_din_en, core_dout_en, busy, err;
   logic [127:0] core_din, core_dout;
   logic         mute = 1'b0, ovr_en = 1'b0;
   logic [4:0]   stub_cnt = '0;
   int           checks = 0, passed = 0;

   sm4_ctrl_if bus();

   sm4_ctrl dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_key_ok(key_ok), .bus(bus),
      .o_core_flag(core_flag), .o_core_din(core_din), .o_core_din_en(core_din_en),
      .i_core_dout(core_dout), .i_core_dout_en(core_dout_en),
      .o_busy(busy), .o_err(err)
   );

   always #5 clk = ~clk;

   // Stub core: strobes its result 31 cycles after the load strobe; not tied to the controller reset.
   always @(posedge clk)
      if (core_din_en) stub_cnt <= 5'd1;
      else if (stub_cnt != 0) stub_cnt <= (stub_cnt == 5'd31) ? 5'd0 : stub_cnt + 5'd1;

   assign core_dout_en = ((stub_cnt == 5'd31) & ~mute) | ovr_en;
   assign core_dout = ovr_en ? OVR : (core_flag && core_din == PT) ? CT :
                      (!core_flag && core_din == CT) ? PT : ~core_din;

   task automatic send(input logic f, input logic [127:0] d, output int lat, output logic [127:0] q, output logic en1);
      bus.i_flag = f; bus.i_din = d; bus.i_din_valid = 1'b1;
      @(negedge clk);
      bus.i_din_valid = 1'b0;
      en1 = core_din_en;
      lat = -1; q = '0;
      for (int n = 1; n <= 100 && lat < 0; n++) begin
         if (n > 1) @(negedge clk);
         if (bus.o_dout_valid) begin lat = n; q = bus.o_dout; end
      end
   endtask

   task automatic drain();
      bus.i_dout_ready = 1'b1;
      for (int n = 0; n < 100 && busy; n++) @(negedge clk);
   endtask

   task automatic test_reset();
      int lat; logic [127:0] q;
      bus.i_flag = 1'b1; bus.i_din = PT; bus.i_din_valid = 1'b1; bus.i_dout_ready = 1'b1;
      #1;
      checks++; if ({busy, bus.o_dout_valid, core_din_en, core_flag, err} !== 5'b0) $display("FAIL reset_ctl got %b want 00000", {busy, bus.o_dout_valid, core_din_en, core_flag, err}); else passed++;
      checks++; if (bus.o_dout !== '0 || core_din !== '0) $display("FAIL reset_data got %h/%h want 0", bus.o_dout, core_din); else passed++;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); bus.i_din_valid = 1'b0;
      checks++; if (busy !== 1'b1 || core_din_en !== 1'b1) $display("FAIL first_accept got busy=%b en=%b want 1 1", busy, core_din_en); else passed++;
      lat = -1; q = '0;
      for (int n = 2; n <= 100 && lat < 0; n++) begin
         @(negedge clk);
         if (bus.o_dout_valid) begin lat = n; q = bus.o_dout; end
      end
      checks++; if (lat !== 33 || q !== CT) $display("FAIL first_block got lat=%0d %h want 33 %h", lat, q, CT); else passed++;
      drain();
   endtask

   task automatic test_encrypt();
      int lat; logic [127:0] q; logic en1;
      checks++; if (bus.o_din_ready !== 1'b1) $display("FAIL enc_ready got %b want 1", bus.o_din_ready); else passed++;
      send(1'b1, PT, lat, q, en1);
      checks++; if (en1 !== 1'b1) $display("FAIL enc_din_en got %b want 1", en1); else passed++;
      checks++; if (lat !== 33) $display("FAIL enc_latency got %0d want 33", lat); else passed++;
      checks++; if (q !== CT) $display("FAIL enc_dout got %h want %h", q, CT); else passed++;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || core_flag !== 1'b1) $display("FAIL enc_idle got busy=%b flag=%b want 0 1", busy, core_flag); else passed++;
   endtask

   task automatic test_decrypt();
      int lat; logic [127:0] q; logic en1;
      send(1'b0, CT, lat, q, en1);
      checks++; if (lat !== 33 || q !== PT) $display("FAIL dec_dout got lat=%0d %h want 33 %h", lat, q, PT); else passed++;
      checks++; if (core_flag !== 1'b0) $display("FAIL dec_flag got %b want 0", core_flag); else passed++;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int lat, bad = 0; logic [127:0] q; logic en1;
      bus.i_dout_ready = 1'b0;
      send(1'b1, PT, lat, q, en1);
      checks++; if (lat !== 33 || q !== CT) $display("FAIL bp_dout got lat=%0d %h want 33 %h", lat, q, CT); else passed++;
      bus.i_flag = 1'b0; bus.i_din = CT; bus.i_din_valid = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (bus.o_dout !== CT || bus.o_dout_valid !== 1'b1 || bus.o_din_ready !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) $display("FAIL bp_hold got %0d bad cycles want 0", bad); else passed++;
      bus.i_dout_ready = 1'b1;
      @(negedge clk);
      checks++; if ({bus.o_dout_valid, busy, bus.o_din_ready} !== 3'b001) $display("FAIL bp_consume got %b want 001", {bus.o_dout_valid, busy, bus.o_din_ready}); else passed++;
      @(negedge clk); bus.i_din_valid = 1'b0;
      checks++; if (busy !== 1'b1 || core_din !== CT) $display("FAIL bp_next_accept got busy=%b %h want 1 %h", busy, core_din, CT); else passed++;
      drain();
      checks++; if (busy !== 1'b0) $display("FAIL bp_drain got busy=%b want 0", busy); else passed++;
   endtask

   task automatic test_gating();
      int bad = 0, lat = -1; logic [127:0] q = '0;
      key_ok = 1'b0; bus.i_flag = 1'b1; bus.i_din = PT; bus.i_din_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (bus.o_din_ready !== 1'b0 || busy !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) $display("FAIL gate_block got %0d bad cycles want 0", bad); else passed++;
      key_ok = 1'b1;
      @(negedge clk); bus.i_din_valid = 1'b0;
      checks++; if (busy !== 1'b1 || core_din_en !== 1'b1) $display("FAIL gate_accept got busy=%b en=%b want 1 1", busy, core_din_en); else passed++;
      repeat (10) @(negedge clk);
      key_ok = 1'b0;
      for (int n = 12; n <= 100 && lat < 0; n++) begin
         @(negedge clk);
         if (bus.o_dout_valid) begin lat = n; q = bus.o_dout; end
      end
      checks++; if (lat !== 33 || q !== CT) $display("FAIL gate_inflight got lat=%0d %h want 33 %h", lat, q, CT); else passed++;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || bus.o_din_ready !== 1'b0) $display("FAIL gate_idle got busy=%b rdy=%b want 0 0", busy, bus.o_din_ready); else passed++;
      key_ok = 1'b1;
   endtask

   task automatic test_ignore_dout_en();
      int lat; logic [127:0] q; logic en1;
      bus.i_dout_ready = 1'b0;
      send(1'b0, CT, lat, q, en1);
      ovr_en = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (bus.o_dout !== PT || bus.o_dout_valid !== 1'b1) $display("FAIL ign_out got %h v=%b want %h 1", bus.o_dout, bus.o_dout_valid, PT); else passed++;
      ovr_en = 1'b0; bus.i_dout_ready = 1'b1;
      @(negedge clk);
      ovr_en = 1'b1;
      repeat (3) @(negedge clk);
      ovr_en = 1'b0;
      checks++; if (bus.o_dout !== PT || bus.o_dout_valid !== 1'b0 || busy !== 1'b0) $display("FAIL ign_idle got %h v=%b busy=%b want %h 0 0", bus.o_dout, bus.o_dout_valid, busy, PT); else passed++;
   endtask

   task automatic test_midrun_reset();
      int stale = 0;
      bus.i_flag = 1'b1; bus.i_din = PT; bus.i_din_valid = 1'b1;
      @(negedge clk); bus.i_din_valid = 1'b0;
      repeat (11) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({busy, bus.o_dout_valid, core_din_en, core_flag, err} !== 5'b0) $display("FAIL mid_reset_ctl got %b want 00000", {busy, bus.o_dout_valid, core_din_en, core_flag, err}); else passed++;
      checks++; if (bus.o_dout !== '0 || core_din !== '0) $display("FAIL mid_reset_data got %h/%h want 0", bus.o_dout, core_din); else passed++;
      @(negedge clk); rst_n = 1'b1;
      repeat (45) begin
         @(negedge clk);
         if (bus.o_dout_valid || busy) stale++;
      end
      checks++; if (stale !== 0 || bus.o_dout !== '0) $display("FAIL mid_reset_stale got %0d cycles dout=%h want 0 0", stale, bus.o_dout); else passed++;
   endtask

   task automatic test_timeout();
      mute = 1'b1; bus.i_flag = 1'b1; bus.i_din = PT; bus.i_din_valid = 1'b1;
      @(negedge clk); bus.i_din_valid = 1'b0;
`ifdef SM4_CTRL_TIMEOUT_EN
      repeat (41) @(negedge clk);
      checks++; if (busy !== 1'b1 || err !== 1'b0) $display("FAIL to_before got busy=%b err=%b want 1 0", busy, err); else passed++;
      @(negedge clk);
      checks++; if ({err, busy, bus.o_din_ready, bus.o_dout_valid} !== 4'b1010) $display("FAIL to_fire got %b want 1010", {err, busy, bus.o_din_ready, bus.o_dout_valid}); else passed++;
      @(negedge clk);
      checks++; if (err !== 1'b1) $display("FAIL to_sticky got %b want 1", err); else passed++;
`else
      repeat (59) @(negedge clk);
      checks++; if (busy !== 1'b1 || err !== 1'b0 || bus.o_dout_valid !== 1'b0) $display("FAIL no_timeout got busy=%b err=%b v=%b want 1 0 0", busy, err, bus.o_dout_valid); else passed++;
`endif
      rst_n = 1'b0; #1;
      @(negedge clk); rst_n = 1'b1; mute = 1'b0;
   endtask

   initial begin
      test_reset();
      test_encrypt();
      test_decrypt();
      test_backpressure();
      test_gating();
      test_ignore_dout_en();
      test_midrun_reset();
      test_timeout();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/sm4_ctrl.md
SM4_CTRL -- requirements
Module: sm4_ctrl

Interface
REQ-001 SHALL have ports i_clk (in, 1, sole clock) and i_rst_n (in, 1, reset); reset is asynchronous and active-low.
REQ-002 SHALL have i_key_ok (in, 1): the expanded key is valid and stable on the core's key input.
REQ-003 SHALL have i_flag (in, 1): 1 = encrypt, 0 = decrypt; sampled with the input block.
REQ-004 SHALL have i_din (in, 128), i_din_valid (in, 1) and o_din_ready (out, 1): input valid/ready handshake.
REQ-005 SHALL have o_dout (out, 128), o_dout_valid (out, 1) and i_dout_ready (in, 1): output valid/ready handshake.
REQ-006 SHALL have core-side ports o_core_flag (out, 1), o_core_din (out, 128), o_core_din_en (out, 1), i_core_dout (in, 128) and i_core_dout_en (in, 1).
REQ-007 SHALL have o_busy (out, 1) and o_err (out, 1).

Function
REQ-008 SHALL implement the FSM IDLE -> LOAD -> RUN -> OUT -> IDLE, with reset state IDLE.
REQ-009 o_din_ready SHALL be 1 only in IDLE with i_key_ok=1; an input is accepted on a clock edge with i_din_valid & o_din_ready.
REQ-010 On accept, SHALL register i_din into o_core_din and i_flag into o_core_flag, then go to LOAD.
REQ-011 o_core_flag SHALL hold its value from accept until the next accept.
REQ-012 In LOAD, o_core_din_en SHALL be 1 for exactly one cycle, then the FSM goes to RUN and clears the 6-bit round counter.
REQ-013 In RUN, the counter SHALL increment every cycle; on i_core_dout_en=1, i_core_dout SHALL be captured into o_dout and the FSM goes to OUT.
REQ-014 Nominal timing: accept at edge T; o_core_din_en high in cycle T+1; i_core_dout_en in cycle T+32; o_dout_valid high from cycle T+33.
REQ-015 In OUT, o_dout_valid=1 and o_dout SHALL be held stable until i_dout_ready=1, then the FSM goes to IDLE.
REQ-016 No new block SHALL be accepted in the cycle the output is consumed; the next accept is earliest one cycle later.
REQ-017 i_core_dout_en asserted outside RUN SHALL be ignored, with no state or data change.
REQ-018 A drop of i_key_ok SHALL only block new accepts; a block already in flight SHALL complete.
REQ-019 o_busy SHALL be 1 in LOAD, RUN and OUT, and 0 in IDLE.
REQ-020 Counter width SHALL be 6 bits and SHALL saturate at 63, never wrapping.

Reset
REQ-021 Asserting i_rst_n=0 SHALL immediately force: FSM to IDLE, counter 0, o_core_din 0, o_core_flag 0, o_core_din_en 0, o_dout 0, o_dout_valid 0, o_busy 0, o_err 0.
REQ-022 Reset mid-operation SHALL discard the in-flight block; no o_dout_valid SHALL follow for that block.
REQ-023 After reset release, the first accept SHALL be possible on the first edge where i_din_valid & i_key_ok are both 1.

Configuration
REQ-024 Macro SM4_CTRL_TIMEOUT_EN, when defined, SHALL enable a watchdog: if the RUN counter reaches 40 without i_core_dout_en, o_err is set and the FSM returns to IDLE with no output.
REQ-025 With SM4_CTRL_TIMEOUT_EN defined, o_err SHALL be sticky until reset, and new accepts SHALL still be allowed.
REQ-026 Without SM4_CTRL_TIMEOUT_EN, o_err SHALL be constant 0 and RUN SHALL wait indefinitely for i_core_dout_en.

Verification
REQ-027 Encrypt case: key and plaintext 0123456789abcdeffedcba9876543210, i_flag=1, real core attached -> o_dout=681edf34d206965e86b3e94f536e4246, o_dout_valid rising exactly 33 cycles after accept.
REQ-028 Decrypt case: i_din=681edf34d206965e86b3e94f536e4246, i_flag=0 -> o_dout=0123456789abcdeffedcba9876543210.
REQ-029 Backpressure: i_dout_ready=0 for 10 cycles -> o_dout stable and o_din_ready=0 throughout; after consume, next accept occurs no earlier than one cycle later.
REQ-030 Gating: i_key_ok=0 with i_din_valid=1 -> no accept; raise i_key_ok -> accept on that edge; drop i_key_ok mid-RUN -> block still completes.
REQ-031 Reset: assert i_rst_n at RUN counter 10 -> all outputs 0 immediately, and no stale o_dout_valid appears afterwards.
REQ-032 Timeout, with SM4_CTRL_TIMEOUT_EN: stub core never asserts i_core_dout_en -> o_err=1 at counter 40, FSM in IDLE, o_din_ready=1; without the macro -> o_busy stays 1.
